bootrom_bus_bridge: RTL

- Sits between the PicoRV32 native memory bus and the 8KB boot ROM BRAM at 0x40000.
- Decodes the ROM window and sequences the ROM's registered read, returning data with a single mem_ready pulse.
- Writes into the ROM window are acknowledged and dropped. Each one is logged as a protection violation for firmware/debug readout.
- Outside the window the block is inert; the top-level bus mux selects other slaves.

---
 rtl/bootrom_bus_bridge.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bootrom_bus_bridge.sv
// ---------------------------------------------------------------------------
// bootrom_bus_bridge
//
// Bridges the PicoRV32 native memory bus onto the boot ROM block RAM that
// lives at BASE_ADDR. Reads are sequenced through the ROM's registered read
// port and answered with a single mem_ready pulse. Writes into the window are
// acknowledged but dropped; each one is recorded as a protection violation
// (sticky flag plus saturating counter) for firmware or debug readout.
// Outside the window the bridge stays inert so the top-level mux can route
// the request to another slave.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   mem_valid     CPU request valid
//   mem_instr     instruction fetch qualifier (informational only)
//   mem_addr      CPU byte address
//   mem_wstrb     byte write strobes, zero means read
//   mem_ready     one-cycle completion pulse (registered)
//   mem_rdata     read data, meaningful while mem_ready is high
//   sel           combinational window hit
//   rom_enable    combinational ROM read enable, high in the accept cycle
//   rom_addr      combinational ROM byte address (offset into the window)
//   rom_rdata     ROM registered read data
//   wr_violation  sticky flag, set by any write into the window
//   viol_count    saturating count of write violations
//   viol_clear    synchronous clear of wr_violation and viol_count
// ---------------------------------------------------------------------------
module bootrom_bus_bridge #(
   parameter logic [31:0] BASE_ADDR   = 32'h0004_0000,
   parameter int          SIZE_BYTES  = 8192,
   parameter int          ROM_LATENCY = 1,
   parameter int          CNT_WIDTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_valid,
   input  logic                          mem_instr,
   input  logic [31:0]                   mem_addr,
   input  logic [3:0]                    mem_wstrb,
   output logic                          mem_ready,
   output logic [31:0]                   mem_rdata,
   output logic                          sel,
   output logic                          rom_enable,
   output logic [$clog2(SIZE_BYTES)-1:0] rom_addr,
   input  logic [31:0]                   rom_rdata,
   output logic                          wr_violation,
   output logic [CNT_WIDTH-1:0]          viol_count,
   input  logic                          viol_clear
);

   localparam int AW = $clog2(SIZE_BYTES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [2:0]  lat_cnt;
   logic [31:0] offset;
   logic        read_accept;
   logic        write_accept;
   logic        unused_instr;

   // Subtracting the base first turns the two-sided window test into a single
   // unsigned compare: addresses below the base wrap to huge offsets and miss.
   assign offset = mem_addr - BASE_ADDR;
   assign sel    = mem_valid && (offset < 32'(SIZE_BYTES));

   // Only an idle bridge accepts, so a request still held during WAIT/DONE
   // can never be taken twice.
   assign read_accept  = (state == IDLE) && sel && (mem_wstrb == 4'b0000);
   assign write_accept = (state == IDLE) && sel && (mem_wstrb != 4'b0000);

   assign rom_enable = read_accept;
   assign rom_addr   = offset[AW-1:0];

   assign unused_instr = mem_instr;

   // Transaction sequencer. A read waits ROM_LATENCY cycles for the ROM's
   // registered output, captures it on the last WAIT cycle and then pulses
   // mem_ready from DONE. A write skips straight to DONE with zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat_cnt   <= 3'd0;
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               mem_ready <= 1'b0;
               if (read_accept) begin
                  lat_cnt <= 3'(ROM_LATENCY);
                  state   <= WAIT;
               end else if (write_accept) begin
                  mem_rdata <= 32'h0;
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 3'd1;
               if (lat_cnt == 3'd1) begin
                  mem_rdata <= rom_rdata;
                  mem_ready <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Violation bookkeeping. A write accepted in the same cycle as a clear
   // takes priority, so that write is still counted as the first violation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_violation <= 1'b0;
         viol_count   <= '0;
      end else if (write_accept) begin
         wr_violation <= 1'b1;
         if (viol_clear) begin
            viol_count <= CNT_ONE;
         end else if (viol_count != CNT_MAX) begin
            viol_count <= viol_count + CNT_ONE;
         end
      end else if (viol_clear) begin
         wr_violation <= 1'b0;
         viol_count   <= '0;
      end
   end

endmodule
